// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//
// Iterative RV32M multiply/divide unit for the execute stage. An operation is
// captured on a start request while the unit is idle (or in its done cycle),
// computed over 32 shift/add or shift/subtract iterations on unsigned
// magnitudes, sign-corrected in one final cycle, and then presented with a
// one-cycle done pulse. Division by zero and signed overflow are resolved at
// accept time and complete on the following cycle.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   start   request to capture op/operands/tag this edge (IDLE or DONE only)
//   kill    synchronous flush; aborts any in-flight op, beats start
//   op      000 mul, 001 mulh, 010 mulhsu, 011 mulhu,
//           100 divu, 101 div, 110 remu, 111 rem
//   src_a   rs1 (multiplicand / dividend)
//   src_b   rs2 (multiplier / divisor)
//   rd_in   destination register tag
//   busy    high while iterating; start is ignored
//   done    one-cycle pulse, result/rd_out valid
//   result  registered result, held until the next completion
//   rd_out  registered tag of the completed op
// ---------------------------------------------------------------------------
module mul_div_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kill,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  src_a,
  input  logic [XLEN-1:0]  src_b,
  input  logic [TAG_W-1:0] rd_in,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] rd_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIVU   = 3'b100;
  localparam logic [2:0] OP_DIV    = 3'b101;
  localparam logic [2:0] OP_REMU   = 3'b110;
  localparam logic [2:0] OP_REM    = 3'b111;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;
  // The counter runs one step past the last iteration; that extra CALC cycle
  // is where the sign fix-up is applied and the result is registered.
  localparam logic [5:0]      LAST_CNT = 6'(XLEN);

  state_t              state_q;
  logic [5:0]          count_q;
  logic [2:0]          op_q;
  logic [TAG_W-1:0]    rd_q;
  logic                a_neg_q;
  logic                b_neg_q;
  // Multiply: the multiplicand magnitude. Divide: the divisor magnitude.
  logic [XLEN-1:0]     opnd_q;
  // Multiply: {product high, remaining multiplier bits}.
  // Divide: low half shifts dividend bits out and quotient bits in.
  logic [2*XLEN-1:0]   prod_q;
  logic [XLEN-1:0]     rem_q;

  // Accept-time decode: signedness, magnitudes and the special cases.
  logic                a_signed;
  logic                b_signed;
  logic                a_neg_in;
  logic                b_neg_in;
  logic [XLEN-1:0]     a_mag;
  logic [XLEN-1:0]     b_mag;
  logic                is_div_in;
  logic                div_zero;
  logic                div_ovf;
  logic [XLEN-1:0]     special_res;

  always_comb begin
    a_signed    = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                  (op == OP_DIV) || (op == OP_REM);
    b_signed    = (op == OP_MUL) || (op == OP_MULH) ||
                  (op == OP_DIV) || (op == OP_REM);
    a_neg_in    = a_signed && src_a[XLEN-1];
    b_neg_in    = b_signed && src_b[XLEN-1];
    a_mag       = a_neg_in ? (~src_a + 1'b1) : src_a;
    b_mag       = b_neg_in ? (~src_b + 1'b1) : src_b;
    is_div_in   = op[2];
    div_zero    = is_div_in && (src_b == '0);
    div_ovf     = ((op == OP_DIV) || (op == OP_REM)) &&
                  (src_a == MIN_NEG) && (src_b == ALL_ONES);
    special_res = '0;
    // op[1] separates the remainder ops from the quotient ops.
    if (div_zero) begin
      special_res = op[1] ? src_a : ALL_ONES;
    end else if (div_ovf) begin
      special_res = op[1] ? '0 : MIN_NEG;
    end
  end

  // One iteration of each algorithm, selected by op_q[2] in the sequencer.
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN:0]       div_shift;
  logic                div_fits;
  logic [XLEN-1:0]     div_diff;
  logic [XLEN-1:0]     div_rem_next;
  logic [2*XLEN-1:0]   div_next;

  always_comb begin
    mul_sum      = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                   (prod_q[0] ? {1'b0, opnd_q} : '0);
    mul_next     = {mul_sum, prod_q[XLEN-1:1]};
    div_shift    = {rem_q, prod_q[XLEN-1]};
    div_fits     = (div_shift >= {1'b0, opnd_q});
    // When the divisor fits the true difference is below the divisor, so the
    // low XLEN bits of the subtraction are exact.
    div_diff     = div_shift[XLEN-1:0] - opnd_q;
    div_rem_next = div_fits ? div_diff : div_shift[XLEN-1:0];
    div_next     = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-2:0], div_fits};
  end

  // Sign fix-up of the finished magnitudes and result selection.
  logic [2*XLEN-1:0]   mul_final;
  logic [XLEN-1:0]     quo_final;
  logic [XLEN-1:0]     rem_final;
  logic [XLEN-1:0]     final_res;

  always_comb begin
    mul_final = (a_neg_q ^ b_neg_q) ? (~prod_q + 1'b1) : prod_q;
    quo_final = (a_neg_q ^ b_neg_q) ? (~prod_q[XLEN-1:0] + 1'b1)
                                    : prod_q[XLEN-1:0];
    rem_final = a_neg_q ? (~rem_q + 1'b1) : rem_q;
    final_res = '0;
    case (op_q)
      OP_MUL:                       final_res = mul_final[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = mul_final[2*XLEN-1:XLEN];
      OP_DIVU, OP_DIV:              final_res = quo_final;
      OP_REMU, OP_REM:              final_res = rem_final;
      default:                      final_res = '0;
    endcase
  end

  // Sequencer and datapath registers. kill outranks everything except reset;
  // start is only honoured in IDLE and DONE so a back-to-back op can be
  // accepted in the done cycle without an idle bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      opnd_q  <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      result  <= '0;
      rd_out  <= '0;
    end else if (kill) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            op_q    <= op;
            rd_q    <= rd_in;
            a_neg_q <= a_neg_in;
            b_neg_q <= b_neg_in;
            count_q <= '0;
            rem_q   <= '0;
            if (is_div_in) begin
              opnd_q <= b_mag;
              prod_q <= {{XLEN{1'b0}}, a_mag};
            end else begin
              opnd_q <= a_mag;
              prod_q <= {{XLEN{1'b0}}, b_mag};
            end
            if (div_zero || div_ovf) begin
              result  <= special_res;
              rd_out  <= rd_in;
              state_q <= DONE;
            end else begin
              state_q <= CALC;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          if (count_q == LAST_CNT) begin
            result  <= final_res;
            rd_out  <= rd_q;
            state_q <= DONE;
          end else begin
            if (op_q[2]) begin
              prod_q <= div_next;
              rem_q  <= div_rem_next;
            end else begin
              prod_q <= mul_next;
            end
            count_q <= count_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
//
// Directed bench for mul_div_unit: a table of operations with hand-computed
// results and latencies, followed by handwritten handshake, kill and reset
// sequences. Latency is the number of clock edges after the accept edge at
// which done is first seen (33 for an iterated op, 0 for a special case).
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIVU   = 3'b100;
  localparam logic [2:0] OP_DIV    = 3'b101;
  localparam logic [2:0] OP_REMU   = 3'b110;
  localparam logic [2:0] OP_REM    = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        kill;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_compared = 0;
  int n_mismatch = 0;

  mul_div_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .kill   (kill),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  // Compare one value against its expectation and keep the tallies.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Present one request for a single accept edge, then scramble the inputs so
  // any late sampling of op/operands shows up as a wrong result.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] r);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    rd_in = r;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = ~o;
    src_a = $urandom;
    src_b = $urandom;
    rd_in = ~r;
  endtask

  // Count edges until done is seen, bounded so a stuck DUT cannot hang us.
  task automatic waitDone(output int edges);
    edges = 0;
    while (done !== 1'b1 && edges < 60) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  initial begin
    int  lat;
    int  pre;
    logic saw_done;

    vecs[0]  = '{OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    vecs[2]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    vecs[4]  = '{OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
    vecs[5]  = '{OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    vecs[6]  = '{OP_DIVU,   32'd100,       32'd7,         32'd14,        33};
    vecs[7]  = '{OP_REMU,   32'd100,       32'd7,         32'd2,         33};
    vecs[8]  = '{OP_DIVU,   32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 0};
    vecs[9]  = '{OP_REMU,   32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 0};
    vecs[10] = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0};
    vecs[11] = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0};
    vecs[12] = '{OP_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    vecs[13] = '{OP_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33};
    vecs[14] = '{OP_DIV,    32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 0};
    vecs[15] = '{OP_REM,    32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 0};
    vecs[16] = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vecs[17] = '{OP_MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33};

    rst   = 1'b1;
    start = 1'b0;
    kill  = 1'b0;
    op    = '0;
    src_a = '0;
    src_b = '0;
    rd_in = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy",   {31'b0, busy}, 32'd0);
    checkOutput("reset_done",   {31'b0, done}, 32'd0);
    checkOutput("reset_result", result,        32'd0);
    checkOutput("reset_rd_out", {27'b0, rd_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven operations.
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1));
      waitDone(lat);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      checkOutput($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
      checkOutput($sformatf("vec%0d_rd_out", i), {27'b0, rd_out}, 32'(i + 1));
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_done_pulse", i), {31'b0, done}, 32'd0);
    end

    // start pulsed while busy must be ignored and not queued.
    applyStimulus(OP_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 5'd3);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    op    = OP_DIVU;
    src_a = 32'd100;
    src_b = 32'd7;
    rd_in = 5'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    pre   = 6;
    waitDone(lat);
    checkOutput("busy_start_latency", 32'(pre + lat), 32'd33);
    checkOutput("busy_start_result",  result, 32'hFFFF_FFEB);
    checkOutput("busy_start_rd_out",  {27'b0, rd_out}, 32'd3);
    @(posedge clk);
    #1;
    checkOutput("busy_start_no_queue", {31'b0, (busy | done)}, 32'd0);

    // start held in the done cycle: second op accepted with no idle gap.
    applyStimulus(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
    waitDone(lat);
    checkOutput("b2b_first_result", result, 32'hFFFF_FFFE);
    start = 1'b1;
    op    = OP_DIVU;
    src_a = 32'd100;
    src_b = 32'd7;
    rd_in = 5'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("b2b_busy_next", {31'b0, busy}, 32'd1);
    waitDone(lat);
    checkOutput("b2b_second_latency", 32'(lat), 32'd33);
    checkOutput("b2b_second_result",  result, 32'd14);
    checkOutput("b2b_second_rd_out",  {27'b0, rd_out}, 32'd5);
    @(posedge clk);
    #1;

    // kill at iteration 10: back to IDLE, no done, outputs untouched.
    applyStimulus(OP_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 5'd7);
    repeat (10) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    checkOutput("kill_busy", {31'b0, busy}, 32'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    checkOutput("kill_no_done", {31'b0, saw_done}, 32'd0);
    checkOutput("kill_result",  result, 32'd14);
    checkOutput("kill_rd_out",  {27'b0, rd_out}, 32'd5);

    // start together with kill is dropped.
    @(negedge clk);
    start = 1'b1;
    kill  = 1'b1;
    op    = OP_DIVU;
    src_a = 32'd100;
    src_b = 32'd0;
    rd_in = 5'd11;
    @(posedge clk);
    #1;
    start = 1'b0;
    kill  = 1'b0;
    checkOutput("kill_start_dropped", {30'b0, busy, done}, 32'd0);
    checkOutput("kill_start_rd_out",  {27'b0, rd_out}, 32'd5);

    // Asynchronous reset mid-CALC clears everything without a clock edge.
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 5'd8);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_busy",   {31'b0, busy}, 32'd0);
    checkOutput("rst_mid_done",   {31'b0, done}, 32'd0);
    checkOutput("rst_mid_result", result, 32'd0);
    checkOutput("rst_mid_rd_out", {27'b0, rd_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    checkOutput("rst_mid_no_done", {31'b0, saw_done}, 32'd0);

    // Unit is usable again after the reset.
    applyStimulus(OP_REMU, 32'd100, 32'd7, 5'd12);
    waitDone(lat);
    checkOutput("post_rst_latency", 32'(lat), 32'd33);
    checkOutput("post_rst_result",  result, 32'd2);
    checkOutput("post_rst_rd_out",  {27'b0, rd_out}, 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
